sample_source: RTL and testbench
================================

# sample_source

Programmable test-signal source that drives the FIR filter's sample input port. It generates a 16-bit signed waveform from a phase accumulator and emits a one-cycle `input_ready` strobe at the sample rate (default 40 kHz from a 1 MHz `ck`). Its output ports are named `in` and `input_ready` so it connects to `fir` by implicit `.*` port matching. It replaces behavioural stimulus in system-level benches and sits in front of `fir` in FPGA demo builds.

## Interface
- `CLK_DIV`, 25: `ck` cycles per sample period (≥2).
- `DATA_W`, 16: sample width.
- `PHASE_W`, 16: phase accumulator width.
- `AMPLITUDE`, 10000: peak magnitude; must satisfy 0 < `AMPLITUDE` < 2^(`DATA_W`-1).
- `ck`  in  1  system clock, rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-low.
- `enable`  in  1  run/hold.
- `freq_word`  in  `PHASE_W`  phase increment per sample; output frequency = `freq_word` × f_sample / 2^`PHASE_W`.
- `wave_sel`  in  1  0 = square, 1 = triangle. Present only with `SAMPLE_SOURCE_TRIANGLE_EN`.
- `in`  out  `DATA_W` signed  current sample.
- `input_ready`  out  1  sample strobe, one `ck` cycle wide.

## Operation
- Divider counter `div_cnt` counts 0..`CLK_DIV`-1 while `enable`=1. A tick occurs when `div_cnt`=`CLK_DIV`-1, and `div_cnt` then wraps to 0.
- On the tick edge:
  - `in` ← wave(`phase`), using the old phase.
  - `phase` ← (`phase` + `freq_word`) mod 2^`PHASE_W`.
  - `input_ready` ← 1.
- On every non-tick edge, `input_ready` ← 0.
- `freq_word` and `wave_sel` are sampled only on the tick edge.
- Square wave: `phase`[MSB]=0 gives +`AMPLITUDE`; `phase`[MSB]=1 gives −`AMPLITUDE`.
- Triangle wave:
  - `lo` = `phase`[`PHASE_W`-2:0].
  - `fold` = MSB ? 2^(`PHASE_W`-1) − `lo` : `lo` (`PHASE_W` bits wide).
  - value = −`AMPLITUDE` + ((2·`AMPLITUDE`·`fold`) >> (`PHASE_W`-1)).
  - The product is unsigned and uses a 32-bit intermediate; the result always lies within ±`AMPLITUDE`, so no saturation is needed.
- While `enable`=0:
  - `div_cnt` is held at 0 and `input_ready`=0.
  - `in` and `phase` hold their values.
- `freq_word`=0 produces a constant output. `freq_word`=2^(`PHASE_W`-1) produces the Nyquist alternation.

## Timing
- Reset (`rst`=0 at a rising edge) sets `div_cnt`=0, `phase`=0, `in`=0, `input_ready`=0.
- Reset mid-period discards the partial count. Reset overrides `enable`.
- First strobe: `CLK_DIV` edges after the first edge sampling `enable`=1. Strobes then repeat every `CLK_DIV` edges (24 low + 1 high at the defaults).
- `in` changes only on the edge that raises `input_ready`, and is stable for the whole strobe cycle and until the next strobe.
- `enable` falling on the would-be tick edge suppresses that tick.
- Latency from `freq_word` change to effect: the next tick's phase update, so the output changes one sample later.

## Configuration
- `SAMPLE_SOURCE_TRIANGLE_EN` defined: the `wave_sel` port and the triangle datapath are compiled in.
- Undefined: `wave_sel` is absent and the output is always square. There is no multiplier in this case.

## Structure
- Package `sample_pkg`:
  - `typedef logic signed [15:0] sample_t`.
  - Constants `F_CLK_HZ`=1_000_000 and `F_SAMPLE_HZ`=40_000.
  - Function `freq_to_word(hz)`.
- Sub-module `sample_strobe`: `CLK_DIV` counter with `enable`, outputting a one-cycle `tick`. It is reusable for any downstream decimator.
- Top level contains the phase accumulator, the wave mapping, and the output registers.

## Test plan
- Reset/idle: `rst`=0 for 3 cycles, then `enable`=0 for 100 cycles → `in`=0 and `input_ready`=0 throughout.
- Strobe cadence: `enable`=1 → first `input_ready` pulse 25 cycles later, exactly 1 cycle wide, then every 25 cycles over 40 periods.
- 5 kHz square: `freq_word`=8192 → samples repeat as +10000 ×4, then −10000 ×4.
- Boundaries:
  - `freq_word`=0 → constant +10000.
  - `freq_word`=32768 → samples alternate +10000, −10000.
  - `freq_word`=0xFFFF → phase wraps; the MSB sequence matches the model.
- Enable/reset mid-period: drop `enable` at cycle 12, raise it again → next strobe 25 cycles after re-enable. Pulse `rst` mid-run → `in`=0 and the phase restarts at 0.
- Triangle (`SAMPLE_SOURCE_TRIANGLE_EN`): `wave_sel`=1, `freq_word`=8192 → samples −10000, −5000, 0, 5000, 10000, 5000, 0, −5000, repeating.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared types and constants for the test-signal source.
//   sample_t      : 16-bit signed sample type
//   F_CLK_HZ      : system clock rate feeding the source
//   F_SAMPLE_HZ   : nominal sample rate
//   freq_to_word  : converts an output frequency in Hz to a 16-bit phase increment
package sample_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int unsigned F_CLK_HZ    = 1_000_000;
  localparam int unsigned F_SAMPLE_HZ = 40_000;

  // freq_word = hz * 2^16 / f_sample, truncated
  function automatic logic [15:0] freq_to_word(input int unsigned hz);
    return 16'((64'(hz) << 16) / 64'(F_SAMPLE_HZ));
  endfunction

endpackage

// File: rtl/sample_strobe.sv
// Sample-rate divider: counts ck cycles while enabled and raises a one-cycle tick
// every CLK_DIV cycles. Reusable for any downstream decimator.
// Ports:
//   ck     in  system clock, rising edge
//   rst    in  synchronous active-low reset
//   enable in  run/hold; while low the count is held at 0
//   tick   out high on the edge where the count wraps (combinational)
module sample_strobe
  import sample_pkg::*;
#(
  parameter int unsigned CLK_DIV = F_CLK_HZ / F_SAMPLE_HZ
) (
  input  logic ck,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_div_cnt;

  // Gated by enable so that dropping enable on the would-be tick edge suppresses it.
  assign tick = enable && (r_div_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge ck) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (!enable || tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sample_source.sv
// Programmable test-signal source for the FIR sample input. A phase accumulator
// advances by freq_word once per sample tick; the old phase is mapped to a square
// (or, optionally, triangle) waveform and registered onto `in` together with a
// one-cycle input_ready strobe.
// Optional feature macro: SAMPLE_SOURCE_TRIANGLE_EN adds the wave_sel port and
// the triangle datapath; without it the output is always square.
// Ports:
//   ck          in  system clock, rising edge
//   rst         in  synchronous active-low reset
//   enable      in  run/hold
//   freq_word   in  phase increment per sample
//   wave_sel    in  0 = square, 1 = triangle (triangle build only)
//   in          out current signed sample
//   input_ready out sample strobe, one ck cycle wide
module sample_source
  import sample_pkg::*;
#(
  parameter int unsigned CLK_DIV   = F_CLK_HZ / F_SAMPLE_HZ,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PHASE_W   = 16,
  parameter int          AMPLITUDE = 10000
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [PHASE_W-1:0]       freq_word,
`ifdef SAMPLE_SOURCE_TRIANGLE_EN
  input  logic                     wave_sel,
`endif
  output logic signed [DATA_W-1:0] in,
  output logic                     input_ready
);

  localparam logic signed [DATA_W-1:0] AMP = DATA_W'(AMPLITUDE);

  logic                     w_tick;
  logic [PHASE_W-1:0]       r_phase;
  logic signed [DATA_W-1:0] r_in;
  logic                     r_input_ready;
  logic signed [DATA_W-1:0] w_square;
  logic signed [DATA_W-1:0] w_wave;

`ifdef SAMPLE_SOURCE_TRIANGLE_EN
  localparam logic [PHASE_W-1:0] HALF = {1'b1, {(PHASE_W-1){1'b0}}};

  logic [PHASE_W-1:0]       w_lo;
  logic [PHASE_W-1:0]       w_fold;
  logic [31:0]              w_prod;
  logic signed [DATA_W-1:0] w_tri;
`endif

  sample_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .ck     (ck),
    .rst    (rst),
    .enable (enable),
    .tick   (w_tick)
  );

  always_comb begin
    w_square = r_phase[PHASE_W-1] ? -AMP : AMP;
    w_wave   = w_square;
`ifdef SAMPLE_SOURCE_TRIANGLE_EN
    // Fold the phase into a 0..HALF ramp, then scale to -AMP..+AMP.
    w_lo   = {1'b0, r_phase[PHASE_W-2:0]};
    w_fold = r_phase[PHASE_W-1] ? (HALF - w_lo) : w_lo;
    w_prod = 32'(2 * AMPLITUDE) * 32'(w_fold);
    w_tri  = $signed(DATA_W'(w_prod >> (PHASE_W - 1))) - AMP;
    if (wave_sel) begin
      w_wave = w_tri;
    end
`endif
  end

  // freq_word and wave_sel only matter on the tick edge.
  always_ff @(posedge ck) begin
    if (!rst) begin
      r_phase       <= '0;
      r_in          <= '0;
      r_input_ready <= 1'b0;
    end else if (w_tick) begin
      r_in          <= w_wave;
      r_phase       <= r_phase + freq_word;
      r_input_ready <= 1'b1;
    end else begin
      r_input_ready <= 1'b0;
    end
  end

  assign in          = r_in;
  assign input_ready = r_input_ready;

endmodule

// File: tb/tb_sample_source.sv
module tb_sample_source;
  import sample_pkg::*;

  localparam int CLK_DIV = 25;
  localparam int A       = 10000;

  logic               ck = 1'b0;
  logic               rst;
  logic               enable;
  logic [15:0]        freq_word;
  logic               wave_sel;
  logic signed [15:0] in;
  logic               input_ready;

  int n_vec = 0;
  int n_err = 0;
  int sb_q[$];
  int cyc = 0;
  int n_strobe = 0;
  bit chk_spacing = 1'b0;

  sample_source u_dut (
    .ck          (ck),
    .rst         (rst),
    .enable      (enable),
    .freq_word   (freq_word),
`ifdef SAMPLE_SOURCE_TRIANGLE_EN
    .wave_sel    (wave_sel),
`endif
    .in          (in),
    .input_ready (input_ready)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, checks width and spacing.
  initial begin
    bit prev_rdy = 1'b0;
    bit have_last = 1'b0;
    int last_cyc = 0;
    int e;
    forever begin
      @(negedge ck);
      if (prev_rdy) check("strobe_width", int'(input_ready), 0);
      if (input_ready) begin
        n_strobe++;
        if (chk_spacing && have_last) check("strobe_spacing", cyc - last_cyc, CLK_DIV);
        last_cyc  = cyc;
        have_last = 1'b1;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: got sample %0d, expected no strobe", int'(in));
        end else begin
          e = sb_q.pop_front();
          check("sample", int'(in), e);
        end
      end
      if (!chk_spacing) have_last = 1'b0;
      prev_rdy = input_ready;
    end
  end

  task automatic tick_wait(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0;
    tick_wait(1);
    rst = 1'b1;
  endtask

  task automatic wait_strobe(output int lat);
    lat = 0;
    do begin
      tick_wait(1);
      lat++;
    end while (!input_ready && lat < 200);
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 5000) begin
      tick_wait(1);
      t++;
    end
    check("drain_leftover", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic run(input logic [15:0] fw);
    do_reset();
    freq_word = fw;
    enable = 1'b1;
    drain();
    enable = 1'b0;
  endtask

  initial begin
    int lat;
    int s0;
    int bad;
    int ph;
    int tri_v[8];
    rst = 1'b0;
    enable = 1'b0;
    freq_word = '0;
    wave_sel = 1'b0;

    check("freq_to_word_5k", int'(freq_to_word(5000)), 8192);
    check("freq_to_word_nyq", int'(freq_to_word(20000)), 32768);

    // Reset then idle
    tick_wait(3);
    check("reset_in", int'(in), 0);
    check("reset_rdy", int'(input_ready), 0);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick_wait(1);
      if (in != 0 || input_ready) bad++;
    end
    check("idle_anomalies", bad, 0);

    // Cadence: 40 periods at freq_word=0
    freq_word = 16'd0;
    for (int i = 0; i < 40; i++) sb_q.push_back(A);
    chk_spacing = 1'b1;
    enable = 1'b1;
    wait_strobe(lat);
    check("first_strobe_latency", lat, CLK_DIV);
    drain();
    enable = 1'b0;
    chk_spacing = 1'b0;

    // 5 kHz square
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 8; k++) sb_q.push_back(k < 4 ? A : -A);
    run(16'd8192);

    // Constant, Nyquist, wrap-around
    for (int i = 0; i < 6; i++) sb_q.push_back(A);
    run(16'd0);
    for (int i = 0; i < 8; i++) sb_q.push_back((i % 2 == 0) ? A : -A);
    run(16'd32768);
    ph = 0;
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back(((ph >> 15) & 1) != 0 ? -A : A);
      ph = (ph + 16'hFFFF) % 65536;
    end
    run(16'hFFFF);

    // 0x6000: phases 0,24576,49152,8192,32768,57344,16384,40960
    sb_q.push_back(A);  sb_q.push_back(A);  sb_q.push_back(-A); sb_q.push_back(A);
    sb_q.push_back(-A); sb_q.push_back(-A); sb_q.push_back(A);  sb_q.push_back(-A);
    run(16'h6000);

    // Enable dropped at cycle 12, then re-enabled
    do_reset();
    freq_word = 16'd0;
    enable = 1'b1;
    tick_wait(12);
    enable = 1'b0;
    s0 = n_strobe;
    tick_wait(30);
    check("no_strobe_disabled", n_strobe, s0);
    sb_q.push_back(A);
    enable = 1'b1;
    wait_strobe(lat);
    check("reenable_latency", lat, CLK_DIV);
    drain();

    // Enable dropped just before the would-be tick edge
    tick_wait(3);
    enable = 1'b0;
    tick_wait(1);
    enable = 1'b1;
    tick_wait(CLK_DIV - 1);
    enable = 1'b0;
    s0 = n_strobe;
    tick_wait(30);
    check("suppressed_tick", n_strobe, s0);
    check("hold_in", int'(in), A);

    // Reset mid-run restarts the phase; reset overrides enable
    do_reset();
    freq_word = 16'd8192;
    sb_q.push_back(A); sb_q.push_back(A); sb_q.push_back(A);
    enable = 1'b1;
    drain();
    tick_wait(10);
    rst = 1'b0;
    tick_wait(1);
    check("midreset_in", int'(in), 0);
    check("midreset_rdy", int'(input_ready), 0);
    sb_q.push_back(A); sb_q.push_back(A); sb_q.push_back(A);
    sb_q.push_back(A); sb_q.push_back(-A);
    rst = 1'b1;
    wait_strobe(lat);
    check("post_reset_latency", lat, CLK_DIV);
    drain();
    enable = 1'b0;

`ifdef SAMPLE_SOURCE_TRIANGLE_EN
    tri_v = '{-10000, -5000, 0, 5000, 10000, 5000, 0, -5000};
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 8; k++) sb_q.push_back(tri_v[k]);
    wave_sel = 1'b1;
    run(16'd8192);
    wave_sel = 1'b0;
`else
    tri_v = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

    tick_wait(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
